// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bundle: ID-side redirect/handshake plus the instruction SRAM port.
// master = fetch queue, slave = ID stage / SRAM side.
interface inst_fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          br_e;
    logic [31:0]   br_addr;
    logic          id_ready;
    logic          out_valid;
    logic [31:0]   out_pc;
    logic [31:0]   out_inst;
    logic [CW-1:0] count;
    logic          inst_sram_en;
    logic [3:0]    inst_sram_wen;
    logic [31:0]   inst_sram_addr;
    logic [31:0]   inst_sram_wdata;
    logic [31:0]   inst_sram_rdata;

    modport master (
        input  br_e, br_addr, id_ready, inst_sram_rdata,
        output out_valid, out_pc, out_inst, count,
               inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata
    );

    modport slave (
        output br_e, br_addr, id_ready, inst_sram_rdata,
        input  out_valid, out_pc, out_inst, count,
               inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: owns the fetch PC, issues SRAM reads and buffers results for ID.
// Optional macro IFQ_BYPASS_EN: empty-queue responses go straight to the output in the same cycle.
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input logic                  clk,
    input logic                  rst,
    inst_fetch_queue_if.master   ifq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;

    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];

    logic          credit_ok, issue, head_valid, bypass, push, pop;
    logic [31:0]   req_addr;

    always_comb begin
        // Credit counts the response still on its way so the FIFO can never overflow.
        credit_ok  = ({1'b0, count_q} + {{CW{1'b0}}, inflight_q}) < (CW+1)'(DEPTH);
        issue      = !rst && (ifq.br_e || credit_ok);
        req_addr   = rst ? RESET_PC : (ifq.br_e ? ifq.br_addr : fetch_pc_q);
        head_valid = (count_q != '0);
`ifdef IFQ_BYPASS_EN
        bypass     = !head_valid && inflight_q && !ifq.br_e;
`else
        bypass     = 1'b0;
`endif
        pop        = head_valid && ifq.id_ready && !ifq.br_e;
        push       = inflight_q && !ifq.br_e && !(bypass && ifq.id_ready);
    end

    always_comb begin
        ifq.out_valid       = head_valid || bypass;
        ifq.out_pc          = 32'h0;
        ifq.out_inst        = 32'h0;
        if (head_valid) begin
            ifq.out_pc   = pc_mem[rd_ptr_q];
            ifq.out_inst = inst_mem[rd_ptr_q];
        end else if (bypass) begin
            ifq.out_pc   = inflight_pc_q;
            ifq.out_inst = ifq.inst_sram_rdata;
        end
        ifq.count           = count_q;
        ifq.inst_sram_en    = issue;
        ifq.inst_sram_addr  = req_addr;
        ifq.inst_sram_wen   = 4'b0000;
        ifq.inst_sram_wdata = 32'h0;
    end

    always_comb begin
        fetch_pc_d    = issue ? req_addr + 32'd4 : fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = issue ? req_addr : inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        if (ifq.br_e) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            pc_mem[wr_ptr_q]   <= inflight_pc_q;
            inst_mem[wr_ptr_q] <= ifq.inst_sram_rdata;
        end
    end
endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Parametrised instruction-fetch queue placed between the instruction SRAM port and the ID stage of the five-stage core. It owns the fetch PC, issues one-word reads to `inst_sram`, buffers returned instructions with their PCs in a DEPTH-entry FIFO, and presents them to ID under a valid/ready handshake. A branch redirect from ID flushes the queue and discards any in-flight response. This lets IF run ahead of ID stalls and replaces the fixed single-register IF/ID coupling.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, minimum 2. Sustained one instruction per cycle requires DEPTH ≥ 4.
- `RESET_PC`, 32'hBFC0_0000: first fetch address after reset.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `br_e`  in  1  branch/jump redirect from ID, single-cycle pulse.
- `br_addr`  in  32  redirect target; word-aligned.
- `id_ready`  in  1  ID accepts the head entry this cycle.
- `out_valid`  out  1  head entry is valid.
- `out_pc`  out  32  PC of head entry.
- `out_inst`  out  32  instruction word of head entry.
- `count`  out  $clog2(DEPTH)+1  occupied FIFO entries.
- `inst_sram_en`  out  1  read request.
- `inst_sram_wen`  out  4  tied 4'b0000.
- `inst_sram_addr`  out  32  request address.
- `inst_sram_wdata`  out  32  tied 32'h0.
- `inst_sram_rdata`  in  32  read data, valid exactly one cycle after the request.

## Operation
- State: `fetch_pc`, FIFO (`pc` and `inst` per entry, with rd/wr pointers that wrap modulo DEPTH), `count`, `inflight` flag, and `inflight_pc`.
- Issue: `inst_sram_en` = !rst && (br_e || (count + inflight < DEPTH)). `inst_sram_addr` = br_e ? br_addr : fetch_pc. On issue, `fetch_pc` <= addr + 4, `inflight` <= 1, and `inflight_pc` <= addr. With no issue, `inflight` <= 0.
- Response: when `inflight`=1, rdata is paired with `inflight_pc` and written at the wr pointer. Writes only happen when the count-based credit check passes, so the FIFO never overflows.
- Pop: when `out_valid && id_ready`, the rd pointer advances.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- Flush (`br_e`=1): at the edge, the FIFO is emptied (pointers reset, `count` <= 0).
  - The response arriving this cycle is discarded.
  - A pop in the same cycle is ignored; flush wins.
  - A new request to `br_addr` is issued in the same cycle, so no redirect bubble is added.
- `out_pc` and `out_inst` read 0 when `out_valid`=0.
- Reset values: `out_valid` 0, `out_pc` 0, `out_inst` 0, `count` 0, `inst_sram_en` 0, `inst_sram_addr` RESET_PC, `fetch_pc` RESET_PC, `inflight` 0, pointers 0.

## Timing
- The first request is issued in the first cycle with `rst`=0.
- Latency without bypass: request in cycle N gives rdata at N+1, written at the N+1 edge; `out_valid` rises at N+2.
- Throughput: one instruction per cycle when DEPTH ≥ 4 and ID is always ready.
- Credit uses the registered `count`, so a pop does not free credit until the following cycle.
- Full: with `count` + `inflight` = DEPTH, `inst_sram_en` stays 0 until a pop has been registered.
- Reset mid-operation: all state returns to reset values at the edge. The response belonging to a pre-reset request is discarded because `inflight` is cleared.

## Configuration
- `IFQ_BYPASS_EN` defined: when the FIFO is empty, `inflight`=1 and `br_e`=0, the response drives `out_valid`/`out_pc`/`out_inst` combinationally in the same cycle.
  - If `id_ready`=1, the entry is consumed and not written.
  - Otherwise it is written normally.
  - Latency: request N gives `out_valid` at N+1.
- Undefined: every response goes through the FIFO, with latency N+2 as above.

## Test plan
- Reset release, `id_ready`=1, SRAM returns PC-as-data:
  - `inst_sram_addr` sequence BFC00000, BFC00004, BFC00008, …
  - `out_pc` and `out_inst` match one-to-one with no gaps after the first valid.
- Fill and drain:
  - Hold `id_ready`=0, DEPTH=4: exactly 4 requests are issued, then `count`=4, `inst_sram_en`=0.
  - Then raise `id_ready`: 4 entries drain in order and fetch resumes at BFC00010.
- Flush with in-flight response: with `count`=2, pulse `br_e` with br_addr=BFC00100 while a response is in flight.
  - That response is dropped; `count`=0 next cycle.
  - The next `out_pc` is BFC00100, then BFC00104.
- `br_e` coincident with `out_valid && id_ready`: the pop is ignored, `count`=0, and no stale PC appears at the output afterwards.
- Pointer wrap: DEPTH=4, 11 push/pop cycles with alternating `id_ready` show no reordering, duplication or loss.
- `IFQ_BYPASS_EN` defined, empty queue, `id_ready`=1: `out_valid` appears one cycle after the request and `count` stays 0.
